mem_arbiter: RTL and testbench

- Shares the single memory port between the instruction-fetch side (read-only) and the data side (read/write) of the pipelined core.
- Sits between the datapath's fetch/MEM stages and the memory (or cache) port.
- Serialises one transaction at a time, registers all downstream requests, and routes mem_resp/mem_rdata back to the granted requester.
- Fixed D-over-I priority with an I-side starvation guard.

---
 rtl/arb_types.sv | 6 +
 rtl/rv32i_types.sv | 4 +
 rtl/mem_arb_perf.sv | 40 ++++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_types.sv
// Types and constants shared by the memory arbiter and its perf counter block.
package arb_types;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic [1:0] {GRANT_NONE, GRANT_I, GRANT_D} grant_t;
  localparam logic [3:0] ARB_RD_MASK = 4'hF;
endpackage

// File: rtl/rv32i_types.sv
// Core-wide RV32I scalar types shared by the datapath and memory-side blocks.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage

// File: rtl/mem_arb_perf.sv
// Grant and fetch-stall counters for mem_arbiter; only built when MEM_ARB_PERF_EN is defined.
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_grant,
  input  logic        d_grant,
  input  logic        i_stall,
  output logic [31:0] perf_i_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_i_stall
);
  logic [31:0] i_grants_q, i_grants_d;
  logic [31:0] d_grants_q, d_grants_d;
  logic [31:0] i_stall_q, i_stall_d;

  // Free-running counters; natural 32-bit wrap is intended.
  always_comb begin
    i_grants_d = i_grants_q + {31'd0, i_grant};
    d_grants_d = d_grants_q + {31'd0, d_grant};
    i_stall_d  = i_stall_q + {31'd0, i_stall};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_grants_q <= '0;
      d_grants_q <= '0;
      i_stall_q  <= '0;
    end else begin
      i_grants_q <= i_grants_d;
      d_grants_q <= d_grants_d;
      i_stall_q  <= i_stall_d;
    end
  end

  assign perf_i_grants = i_grants_q;
  assign perf_d_grants = d_grants_q;
  assign perf_i_stall  = i_stall_q;
endmodule
`endif

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: D-over-I priority with an I starvation guard.
// Define MEM_ARB_PERF_EN to add the perf_* counter outputs.
module mem_arbiter
  import rv32i_types::*, arb_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_read,
  input  rv32i_word  i_address,
  output rv32i_word  i_rdata,
  output logic       i_resp,
  input  logic       d_read,
  input  logic       d_write,
  input  logic [3:0] d_byte_enable,
  input  rv32i_word  d_address,
  input  rv32i_word  d_wdata,
  output rv32i_word  d_rdata,
  output logic       d_resp,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_byte_enable,
  output rv32i_word  mem_address,
  output rv32i_word  mem_wdata,
  input  logic       mem_resp,
  input  rv32i_word  mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_i_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_i_stall
`endif
);
  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  arb_state_t state_q, state_d;
  grant_t     grant;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic [3:0] mem_be_q, mem_be_d;
  rv32i_word  mem_addr_q, mem_addr_d;
  rv32i_word  mem_wdata_q, mem_wdata_d;
  logic       d_pending;

  assign d_pending = d_read | d_write;

  // Arbitration only happens in IDLE, which gives the bubble between transactions.
  always_comb begin
    grant = GRANT_NONE;
    if (state_q == IDLE) begin
      if (d_pending && (!i_read || (starve_cnt_q < LIMIT))) grant = GRANT_D;
      else if (i_read)                                      grant = GRANT_I;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_resp       = 1'b0;
    d_resp       = 1'b0;

    case (grant)
      GRANT_D: begin
        state_d     = SERVE_D;
        mem_write_d = d_write;
        mem_read_d  = ~d_write;
        mem_be_d    = d_write ? d_byte_enable : ARB_RD_MASK;
        mem_addr_d  = d_address;
        mem_wdata_d = d_wdata;
        if (i_read && (starve_cnt_q < LIMIT)) starve_cnt_d = starve_cnt_q + 4'd1;
      end
      GRANT_I: begin
        state_d      = SERVE_I;
        mem_read_d   = 1'b1;
        mem_write_d  = 1'b0;
        mem_be_d     = ARB_RD_MASK;
        mem_addr_d   = i_address;
        starve_cnt_d = 4'd0;
      end
      default: ;
    endcase

    if (mem_resp && (state_q != IDLE)) begin
      i_resp      = (state_q == SERVE_I);
      d_resp      = (state_q == SERVE_D);
      state_d     = IDLE;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_be_q     <= 4'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = mem_be_q;
  assign mem_address     = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign i_rdata         = mem_rdata;
  assign d_rdata         = mem_rdata;

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf u_perf (
    .clk           (clk),
    .rst_n         (rst),
    .i_grant       (grant == GRANT_I),
    .d_grant       (grant == GRANT_D),
    .i_stall       (i_read & ~i_resp),
    .perf_i_grants (perf_i_grants),
    .perf_d_grants (perf_d_grants),
    .perf_i_stall  (perf_i_stall)
  );
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: the bench plays both requesters and the memory,
// and predicts each transaction from the arbitration rules and a word-addressed memory model.
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read, i_resp, d_read, d_write, d_resp;
  logic [31:0] i_address, i_rdata, d_address, d_wdata, d_rdata;
  logic [3:0]  d_byte_enable, mem_byte_enable;
  logic        mem_read, mem_write, mem_resp;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_i_stall;
`endif

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants), .perf_i_stall(perf_i_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one outstanding transaction at a time.
  bit          busy, m_side_i, m_write;
  int          lat_left, starve;
  logic        exp_read, exp_write;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata;
  int          exp_i_grants, exp_d_grants, exp_i_stall;

  // Requester intent, held until the matching resp.
  bit          i_pend, d_pend, d_is_wr, d_also_rd;
  logic [31:0] i_addr_r, d_addr_r, d_wdata_r;
  logic [3:0]  d_be_r;

  bit          rand_mode, d_auto, prev_active;
  int          forced_lat;
  logic [31:0] mem_model [logic [31:0]];
  bit          obs_log[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return ~a;
  endfunction

  function automatic void memWrite(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] v = memRead(a);
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = w[8*b +: 8];
    mem_model[a] = v;
  endfunction

  task automatic newD(input bit wr, input bit also_rd, input logic [31:0] a,
                      input logic [31:0] w, input logic [3:0] be);
    d_pend = 1'b1; d_is_wr = wr; d_also_rd = also_rd;
    d_addr_r = a; d_wdata_r = w; d_be_r = be;
  endtask

  task automatic applyStimulus();
    if (!i_pend && $urandom_range(0, 2) == 0) begin
      i_pend   = 1'b1;
      i_addr_r = {20'd0, 10'($urandom), 2'b00};
    end
    if (!d_pend && $urandom_range(0, 2) == 0)
      newD($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           32'h8000 + {26'd0, 4'($urandom), 2'b00}, $urandom(), 4'($urandom));
  endtask

  function automatic int pickLat();
    return (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
  endfunction

  function automatic void resetModel();
    busy = 0; starve = 0; exp_read = 0; exp_write = 0; exp_be = 0;
    exp_addr = 0; exp_wdata = 0; prev_active = 0;
    exp_i_grants = 0; exp_d_grants = 0; exp_i_stall = 0;
  endfunction

  // One clock cycle: drive at negedge, check combinational resp mid-low-phase,
  // advance the model, then check registered mem_* just after the rising edge.
  task automatic stepCycle();
    bit          resp_now;
    logic [31:0] rd_exp;
    @(negedge clk);
    if (rand_mode) applyStimulus();
    if (d_auto && !d_pend) newD(1'b1, 1'b0, 32'h8010, $urandom(), 4'hF);
    i_read        = i_pend;
    i_address     = i_addr_r;
    d_write       = d_pend && d_is_wr;
    d_read        = d_pend && (!d_is_wr || d_also_rd);
    d_address     = d_addr_r;
    d_wdata       = d_wdata_r;
    d_byte_enable = d_be_r;
    resp_now      = busy && (lat_left == 0);
    rd_exp        = memRead(exp_addr);
    mem_resp      = resp_now || (rand_mode && !busy && ($urandom_range(0, 3) == 0));
    mem_rdata     = (resp_now && !m_write) ? rd_exp : $urandom();
    #2;
    checkOutput("i_resp", 32'(i_resp), 32'(resp_now && m_side_i));
    checkOutput("d_resp", 32'(d_resp), 32'(resp_now && !m_side_i));
    if (resp_now && !m_write) begin
      if (m_side_i) checkOutput("i_rdata", i_rdata, rd_exp);
      else          checkOutput("d_rdata", d_rdata, rd_exp);
    end
    if (i_pend && !(resp_now && m_side_i)) exp_i_stall++;

    if (resp_now) begin
      if (m_write) memWrite(exp_addr, exp_wdata, exp_be);
      if (m_side_i) i_pend = 1'b0; else d_pend = 1'b0;
      busy = 0; exp_read = 0; exp_write = 0;
    end else if (busy) begin
      lat_left--;
    end else if (d_pend && (!i_pend || starve < LIMIT)) begin
      if (i_pend) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
      m_side_i = 0; m_write = d_is_wr;
      exp_read = !d_is_wr; exp_write = d_is_wr;
      exp_be = d_is_wr ? d_be_r : 4'hF;
      exp_addr = d_addr_r; exp_wdata = d_wdata_r;
      busy = 1; lat_left = pickLat(); exp_d_grants++;
    end else if (i_pend) begin
      starve = 0;
      m_side_i = 1; m_write = 0;
      exp_read = 1; exp_write = 0; exp_be = 4'hF; exp_addr = i_addr_r;
      busy = 1; lat_left = pickLat(); exp_i_grants++;
    end

    @(posedge clk); #1;
    checkOutput("mem_read", 32'(mem_read), 32'(exp_read));
    checkOutput("mem_write", 32'(mem_write), 32'(exp_write));
    checkOutput("mem_address", mem_address, exp_addr);
    checkOutput("mem_wdata", mem_wdata, exp_wdata);
    if (busy) checkOutput("mem_byte_enable", 32'(mem_byte_enable), 32'(exp_be));
    if ((mem_read || mem_write) && !prev_active) obs_log.push_back(mem_address >= 32'h8000);
    prev_active = mem_read || mem_write;
  endtask

  task automatic runUntilIdle(input int max_cycles);
    int n = 0;
    while ((busy || i_pend || d_pend) && n < max_cycles) begin
      stepCycle();
      n++;
    end
    checkOutput("idle_timeout", 32'(busy || i_pend || d_pend), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit exp_pat [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int guard;

    rst = 1'b0; i_read = 0; i_address = 0; d_read = 0; d_write = 0;
    d_byte_enable = 0; d_address = 0; d_wdata = 0; mem_resp = 0; mem_rdata = 0;
    i_pend = 0; d_pend = 0; d_is_wr = 0; d_also_rd = 0;
    i_addr_r = 0; d_addr_r = 0; d_wdata_r = 0; d_be_r = 0;
    m_side_i = 0; m_write = 0; lat_left = 0;
    rand_mode = 0; d_auto = 0; forced_lat = 2;
    resetModel();

    repeat (3) @(negedge clk);
    checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
    checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
    checkOutput("rst_mem_be", 32'(mem_byte_enable), 32'd0);
    checkOutput("rst_mem_address", mem_address, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_resps", 32'({i_resp, d_resp}), 32'd0);
    rst = 1'b1;

    // Single fetch at 0x60 returning an addi-nop encoding.
    $display("[TB] fetch at 0x60");
    mem_model[32'h60] = 32'h0000_0013;
    i_pend = 1; i_addr_r = 32'h60;
    stepCycle();
    checkOutput("tp1_mem_read", 32'(mem_read), 32'd1);
    checkOutput("tp1_mem_address", mem_address, 32'h60);
    runUntilIdle(20);

    // Store with partial mask, d_read also high (write must win).
    $display("[TB] partial store with d_read also asserted");
    newD(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
    stepCycle();
    checkOutput("tp2_mem_write", 32'(mem_write), 32'd1);
    checkOutput("tp2_mem_read", 32'(mem_read), 32'd0);
    checkOutput("tp2_mem_be", 32'(mem_byte_enable), 32'h3);
    checkOutput("tp2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    runUntilIdle(20);

    // Simultaneous I and D requests: D first, then I.
    $display("[TB] simultaneous I/D requests");
    obs_log.delete();
    i_pend = 1; i_addr_r = 32'h80;
    newD(1'b0, 1'b0, 32'h8020, 32'h0, 4'h0);
    runUntilIdle(30);
    checkOutput("tp3_grants", 32'(obs_log.size()), 32'd2);
    if (obs_log.size() >= 2) begin
      checkOutput("tp3_first_is_d", 32'(obs_log[0]), 32'd1);
      checkOutput("tp3_second_is_i", 32'(obs_log[1]), 32'd0);
    end

    // Starvation guard: I held while D keeps re-requesting.
    $display("[TB] starvation guard");
    obs_log.delete();
    i_pend = 1; i_addr_r = 32'h44; d_auto = 1;
    guard = 0;
    while (obs_log.size() < 6 && guard < 300) begin
      stepCycle();
      guard++;
    end
    d_auto = 0;
    runUntilIdle(50);
    checkOutput("starve_grants", 32'(obs_log.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      if (k < obs_log.size()) checkOutput($sformatf("starve_grant_%0d", k), 32'(obs_log[k]), 32'(exp_pat[k]));

    // Reset during a store; the held fetch must be served afterwards.
    $display("[TB] reset mid store");
    forced_lat = 5;
    i_pend = 1; i_addr_r = 32'h90;
    newD(1'b1, 1'b0, 32'h8030, 32'h1234_5678, 4'hF);
    stepCycle();
    stepCycle();
    checkOutput("rmid_mem_write_before", 32'(mem_write), 32'd1);
    #2;
    rst = 1'b0;
    d_pend = 0; d_write = 0; d_read = 0; mem_resp = 1'b1;
    #1;
    checkOutput("rmid_mem_write", 32'(mem_write), 32'd0);
    checkOutput("rmid_d_resp", 32'(d_resp), 32'd0);
    checkOutput("rmid_mem_address", mem_address, 32'd0);
    resetModel();
    @(posedge clk); #1;
    checkOutput("rmid_held_read", 32'(mem_read), 32'd0);
    mem_resp = 1'b0;
    #2;
    rst = 1'b1;
    forced_lat = 1;
    runUntilIdle(20);

    // Randomized traffic with random latency and stray mem_resp in IDLE.
    $display("[TB] random traffic");
    rand_mode = 1; forced_lat = -1;
    repeat (400) stepCycle();
    rand_mode = 0;
    runUntilIdle(60);

`ifdef MEM_ARB_PERF_EN
    checkOutput("perf_i_grants", perf_i_grants, 32'(exp_i_grants));
    checkOutput("perf_d_grants", perf_d_grants, 32'(exp_d_grants));
    checkOutput("perf_i_stall", perf_i_stall, 32'(exp_i_stall));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
